// File: rtl/output_port_packet_arbiter_if.sv
// Handshake bundle between the upstream requesters of one output port and its packet arbiter.
// The slave side is the arbiter itself; the master side belongs to whoever drives the requests.
interface output_port_packet_arbiter_if #(
    parameter int AGENTS_NUM  = 5,
    parameter int AGENTS_SIZE = $clog2(AGENTS_NUM)
) ();

    logic [AGENTS_NUM-1:0]  request;
    logic [AGENTS_NUM-1:0]  tail;
    logic                   stall;
    logic [AGENTS_NUM-1:0]  grant;
    logic                   valid;
    logic                   locked;
    logic [AGENTS_SIZE-1:0] owner;

    modport master (
        output request,
        output tail,
        output stall,
        input  grant,
        input  valid,
        input  locked,
        input  owner
    );

    modport slave (
        input  request,
        input  tail,
        input  stall,
        output grant,
        output valid,
        output locked,
        output owner
    );

endinterface

// File: rtl/output_port_packet_arbiter.sv
// Wormhole round-robin arbiter for one output port: a winning head flit locks the port to its
// requester until that requester's tail flit is granted; the grant is combinational (zero latency).
module output_port_packet_arbiter #(
    parameter int AGENTS_NUM  = 5,
    parameter int AGENTS_SIZE = $clog2(AGENTS_NUM)
) (
    input  logic                          clk,
    input  logic                          rst,
    output_port_packet_arbiter_if.slave   bus
);

    localparam logic [AGENTS_SIZE-1:0] LAST_INDEX = AGENTS_SIZE'(AGENTS_NUM - 1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t                 state;
    logic [AGENTS_SIZE-1:0] owner;
    logic [AGENTS_SIZE-1:0] rr_ptr;

    logic                   found;
    logic [AGENTS_SIZE-1:0] winner;
    logic [AGENTS_SIZE-1:0] candidate;
    logic [AGENTS_NUM-1:0]  grant;
    logic                   grant_tail;

    // Round-robin scan starting at rr_ptr; the wrap is explicit so non-power-of-2 sizes never
    // visit indices that do not exist.
    always_comb begin
        found     = 1'b0;
        winner    = '0;
        candidate = rr_ptr;
        for (int i = 0; i < AGENTS_NUM; i++) begin
            if (!found && bus.request[candidate]) begin
                found  = 1'b1;
                winner = candidate;
            end
            candidate = (candidate == LAST_INDEX) ? '0 : candidate + 1'b1;
        end
    end

    // While locked only the owner can be served; reset forces the grant low even though the
    // registers are already cleared, so nothing leaks out during the reset pulse itself.
    always_comb begin
        grant      = '0;
        grant_tail = 1'b0;
        if (!rst && !bus.stall) begin
            if (state == IDLE) begin
                if (found) begin
                    grant[winner] = 1'b1;
                    grant_tail    = bus.tail[winner];
                end
            end else if (bus.request[owner]) begin
                grant[owner] = 1'b1;
                grant_tail   = bus.tail[owner];
            end
        end
    end

    // Priority only moves when a new packet wins; it stays frozen while a packet is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        rr_ptr <= (winner == LAST_INDEX) ? '0 : winner + 1'b1;
                        if (!grant_tail) begin
                            state <= LOCKED;
                            owner <= winner;
                        end
                    end
                end
                LOCKED: begin
                    if (|grant && grant_tail) begin
                        state <= IDLE;
                        owner <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    owner <= '0;
                end
            endcase
        end
    end

    assign bus.grant  = grant;
    assign bus.valid  = |grant;
    assign bus.locked = (state == LOCKED);
    assign bus.owner  = owner;

endmodule

// File: tb/tb_output_port_packet_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic, all
// compared every cycle against a queue-free packet-level model of the arbitration rules.
module tb_output_port_packet_arbiter;

    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    output_port_packet_arbiter_if #(.AGENTS_NUM(5)) if5 ();
    output_port_packet_arbiter_if #(.AGENTS_NUM(3)) if3 ();

    output_port_packet_arbiter #(.AGENTS_NUM(5)) dut5 (
        .clk (clk),
        .rst (rst),
        .bus (if5.slave)
    );

    output_port_packet_arbiter #(.AGENTS_NUM(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (if3.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model state per instance: 0 is the 5-agent port, 1 is the 3-agent port.
    int m_n [2] = '{5, 3};
    bit m_locked [2];
    int m_owner [2];
    int m_ptr [2];

    function automatic logic [4:0] model_grant(int k, logic [4:0] req, logic stall, logic in_reset);
        logic [4:0] g;
        int idx;
        g = '0;
        if (in_reset || stall) return g;
        if (m_locked[k]) begin
            if (req[m_owner[k]]) g[m_owner[k]] = 1'b1;
            return g;
        end
        for (int off = 0; off < m_n[k]; off++) begin
            idx = (m_ptr[k] + off) % m_n[k];
            if (req[idx]) begin
                g[idx] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    function automatic void model_update(int k, logic [4:0] g, logic [4:0] tl);
        int idx;
        idx = -1;
        for (int i = 0; i < 5; i++) if (g[i]) idx = i;
        if (idx < 0) return;
        if (!m_locked[k]) begin
            m_ptr[k] = (idx + 1) % m_n[k];
            if (!tl[idx]) begin
                m_locked[k] = 1'b1;
                m_owner[k]  = idx;
            end
        end else if (tl[m_owner[k]]) begin
            m_locked[k] = 1'b0;
            m_owner[k]  = 0;
        end
    endfunction

    // Inputs change just after posedge; outputs are compared against the model on the negedge.
    always @(negedge clk) begin
        logic [4:0] req, tl, eg, ag;
        logic       st, av, al;
        int         ao;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                req = if5.request; tl = if5.tail; st = if5.stall;
                ag = if5.grant; av = if5.valid; al = if5.locked; ao = int'(if5.owner);
            end else begin
                req = {2'b00, if3.request}; tl = {2'b00, if3.tail}; st = if3.stall;
                ag = {2'b00, if3.grant}; av = if3.valid; al = if3.locked; ao = int'(if3.owner);
            end
            if (rst) begin
                m_locked[k] = 1'b0;
                m_owner[k]  = 0;
                m_ptr[k]    = 0;
            end
            eg = model_grant(k, req, st, rst);
            checks += 4;
            if (ag !== eg) begin
                failures++;
                $display("[TB] FAIL model_grant[%0d] t=%0t: got %b expected %b", k, $time, ag, eg);
            end
            if (av !== (|eg)) begin
                failures++;
                $display("[TB] FAIL model_valid[%0d] t=%0t: got %b expected %b", k, $time, av, |eg);
            end
            if (al !== m_locked[k]) begin
                failures++;
                $display("[TB] FAIL model_locked[%0d] t=%0t: got %b expected %b", k, $time, al, m_locked[k]);
            end
            if (ao != m_owner[k]) begin
                failures++;
                $display("[TB] FAIL model_owner[%0d] t=%0t: got %0d expected %0d", k, $time, ao, m_owner[k]);
            end
            if (!rst) model_update(k, eg, tl);
        end
    end

    task automatic apply_stimulus(input logic [4:0] req, input logic [4:0] tl, input logic st);
        @(posedge clk);
        #1;
        if5.request = req;
        if5.tail    = tl;
        if5.stall   = st;
        if3.request = '0;
        if3.tail    = '0;
        if3.stall   = 1'b0;
    endtask

    task automatic check_output(input string name, input logic [4:0] eg, input logic el, input int eo);
        #2;
        checks += 3;
        if (if5.grant !== eg) begin
            failures++;
            $display("[TB] FAIL %s grant: got %b expected %b", name, if5.grant, eg);
        end
        if (if5.locked !== el) begin
            failures++;
            $display("[TB] FAIL %s locked: got %b expected %b", name, if5.locked, el);
        end
        if (int'(if5.owner) != eo) begin
            failures++;
            $display("[TB] FAIL %s owner: got %0d expected %0d", name, if5.owner, eo);
        end
    endtask

    task automatic check_output3(input string name, input logic [2:0] eg);
        #2;
        checks++;
        if (if3.grant !== eg) begin
            failures++;
            $display("[TB] FAIL %s grant3: got %b expected %b", name, if3.grant, eg);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        if5.request = '0; if5.tail = '0; if5.stall = 1'b0;
        if3.request = '0; if3.tail = '0; if3.stall = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [4:0] rr_expect [6] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};

    initial begin
        rst = 1'b1;
        if5.request = 5'b11111; if5.tail = '0; if5.stall = 1'b0;
        if3.request = '0;       if3.tail = '0; if3.stall = 1'b0;

        // Reset holds grant low, then the first unreset cycle serves requester 0.
        check_output("reset", 5'b00000, 1'b0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_output("reset_release", 5'b00001, 1'b0, 0);

        pulse_reset();
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(5'b11111, 5'b11111, 1'b0);
            check_output($sformatf("round_robin_%0d", i), rr_expect[i], 1'b0, 0);
        end

        pulse_reset();
        apply_stimulus(5'b01010, 5'b00000, 1'b0);
        check_output("worm_head", 5'b00010, 1'b0, 0);
        apply_stimulus(5'b01010, 5'b00000, 1'b0);
        check_output("worm_body", 5'b00010, 1'b1, 1);
        apply_stimulus(5'b01010, 5'b00010, 1'b0);
        check_output("worm_tail", 5'b00010, 1'b1, 1);
        apply_stimulus(5'b01010, 5'b00000, 1'b0);
        check_output("worm_next", 5'b01000, 1'b0, 0);

        pulse_reset();
        apply_stimulus(5'b00100, 5'b00000, 1'b0);
        check_output("bubble_head", 5'b00100, 1'b0, 0);
        apply_stimulus(5'b00000, 5'b00000, 1'b0);
        check_output("bubble_1", 5'b00000, 1'b1, 2);
        apply_stimulus(5'b11011, 5'b00000, 1'b0);
        check_output("bubble_2", 5'b00000, 1'b1, 2);
        apply_stimulus(5'b11111, 5'b00100, 1'b1);
        check_output("stalled_tail", 5'b00000, 1'b1, 2);
        apply_stimulus(5'b11111, 5'b00100, 1'b0);
        check_output("tail_after_stall", 5'b00100, 1'b1, 2);
        apply_stimulus(5'b11111, 5'b00000, 1'b0);
        check_output("after_tail", 5'b01000, 1'b0, 0);

        pulse_reset();
        @(posedge clk);
        #1;
        if3.request = 3'b100; if3.tail = 3'b100;
        check_output3("wrap_single", 3'b100);
        @(posedge clk);
        #1;
        if3.request = 3'b101; if3.tail = 3'b111;
        check_output3("wrap_to_zero", 3'b001);

        pulse_reset();
        apply_stimulus(5'b10000, 5'b00000, 1'b0);
        check_output("mid_head", 5'b10000, 1'b0, 0);
        apply_stimulus(5'b10000, 5'b00000, 1'b0);
        check_output("mid_body", 5'b10000, 1'b1, 4);
        @(posedge clk);
        #1;
        rst = 1'b1;
        check_output("mid_reset", 5'b00000, 1'b0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        if5.request = 5'b10001;
        check_output("mid_release", 5'b00001, 1'b0, 0);

        // Random traffic with occasional resets; the negedge model compare does all checking.
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            #1;
            rst         = ($urandom_range(0, 99) == 0);
            if5.request = 5'($urandom);
            if5.tail    = 5'($urandom) & 5'($urandom);
            if5.stall   = ($urandom_range(0, 5) == 0);
            if3.request = 3'($urandom);
            if3.tail    = 3'($urandom) & 3'($urandom);
            if3.stall   = ($urandom_range(0, 5) == 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/output_port_packet_arbiter.md
# output_port_packet_arbiter

- Per-output-port wormhole arbiter, one instance per output port.
- Shares the port among up to AGENTS_NUM upstream requesters (input ports) with round-robin priority.
- Once a packet's head flit wins, the port stays locked to that requester until its tail flit is granted.
- Sits beside the switch allocator: its grant drives the crossbar input select and the input-block VC read for that output port.

## Interface
- AGENTS_NUM, default 5 (PORT_NUM): number of requesters.
- AGENTS_SIZE, default $clog2(AGENTS_NUM): width of owner/pointer indices.
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- request_i  input  AGENTS_NUM  per-requester request: a flit is ready for this output.
- tail_i  input  AGENTS_NUM  per-requester flag: the requesting flit is a tail; a head+tail single-flit packet asserts it.
- stall_i  input  1  downstream not accepting (on/off flow control off); blocks all grants.
- grant_o  output  AGENTS_NUM  one-hot or zero grant, combinational, valid this cycle.
- valid_o  output  1  OR of grant_o.
- locked_o  output  1  port held by an in-flight packet (state LOCKED).
- owner_o  output  AGENTS_SIZE  index of the locking requester; 0 when not locked.

## Operation
- State machine with two states.
  - IDLE: no packet in flight.
  - LOCKED: packet from owner in flight.
- Registered state: state, owner (AGENTS_SIZE), rr_ptr (AGENTS_SIZE, highest-priority index).
- IDLE, stall_i=0, any request_i bit set:
  - Winner is the first set request scanning rr_ptr, rr_ptr+1, …, wrapping modulo AGENTS_NUM.
  - grant_o = one-hot(winner).
  - Next cycle rr_ptr = (winner+1) mod AGENTS_NUM; wrap from AGENTS_NUM-1 goes to 0, including non-power-of-2 AGENTS_NUM.
  - If tail_i[winner]=0: go to LOCKED, owner=winner.
  - If tail_i[winner]=1: stay IDLE (single-flit packet).
- IDLE, stall_i=1 or no request: grant_o=0; rr_ptr, state and owner unchanged.
- LOCKED:
  - grant_o = one-hot(owner) iff request_i[owner]=1 and stall_i=0, else 0.
  - Requests from non-owners are ignored, whatever their state.
  - Granted flit with tail_i[owner]=1: next state IDLE, owner cleared to 0.
  - Otherwise stay LOCKED.
  - rr_ptr does not change in LOCKED.
- Owner bubbles (request_i[owner]=0) keep the lock indefinitely. No timeout.
- Fairness: after a packet completes, its requester has lowest priority, so each requester waits at most AGENTS_NUM-1 packets.
- tail_i is sampled only together with a granted request; it is ignored otherwise.
- A request index at or above AGENTS_NUM does not exist; indices wrap only within 0..AGENTS_NUM-1.

## Timing
- Grant latency is zero cycles: grant_o, valid_o are combinational from request_i, tail_i, stall_i, state, owner, rr_ptr.
- locked_o, owner_o come from registers only (no combinational input path).
- State, owner and rr_ptr update on the rising clk edge after the grant cycle.
- A new packet can be granted in the cycle immediately after a tail grant; no dead cycle.
- Back-to-back single-flit packets from different requesters are granted one per cycle.
- Reset values: state IDLE, rr_ptr=0, owner=0, locked_o=0, owner_o=0.
- While rst=1, grant_o=0 and valid_o=0 regardless of inputs.
- Reset asserted mid-packet: the lock is dropped immediately (asynchronously). After release, arbitration restarts from rr_ptr=0.
- Simultaneous stall_i=1 and tail request in LOCKED: no grant, stay LOCKED. The tail is granted on the first unstalled cycle.

## Test plan
- Reset/idle:
  - Stimulus: assert rst with request_i=5'b11111, stall_i=0.
  - Required: grant_o=0, locked_o=0, owner_o=0.
  - Then: release rst, same inputs. Required: first cycle grant_o=5'b00001.
- Round-robin single-flit packets:
  - Stimulus: request_i=5'b11111, tail_i=5'b11111 held for 6 cycles.
  - Required: grants 00001, 00010, 00100, 01000, 10000, 00001; locked_o stays 0.
- Wormhole lock:
  - Stimulus: requesters 1 and 3 request; requester 1 sends head, body, tail over 3 cycles.
  - Required: grant_o=00010 for 3 cycles with locked_o=1 and owner_o=1 after the head; grant_o=01000 on the 4th cycle.
- Bubble and stall inside a packet:
  - Stimulus: owner 2 is locked; request_i[2] drops for 2 cycles, then stall_i=1 for 1 cycle with request_i=5'b11111.
  - Required: grant_o=0 for all 3 cycles, locked_o=1, owner_o=2.
  - Then: the tail is granted on the next unstalled cycle.
- Pointer wrap with AGENTS_NUM=3:
  - Stimulus: requester 2 sends a single flit, then requests 3'b101.
  - Required: next grant is 3'b001 (rr_ptr wrapped to 0).
- Reset mid-packet:
  - Stimulus: assert rst while LOCKED with owner 4.
  - Required: locked_o=0 and grant_o=0 immediately.
  - Then: after release with request_i=5'b10001, required grant_o=5'b00001.
